mcycle_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the shared MCycle multi-cycle multiply/divide unit. It accepts multiply/divide requests from two requesters, grants MCycle to one at a time, and latches that requester's op and operands. It drives a single-cycle Start pulse, tracks MCycle's Busy to completion, and returns the captured Result1/Result2 with a one-cycle acknowledge. It sits between the processor-side requesters (main pipeline, auxiliary engine) and one MCycle instance, which shares CLK and RESET.

---
 rtl/mcycle_arbiter.sv | 134 +++++++++++++
 tb/tb_mcycle_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_arbiter.sv
// Two-port round-robin arbiter/sequencer for a shared MCycle multiply/divide unit.
// Grants one requester at a time, issues a single Start pulse and returns captured results.
module mcycle_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Req1,
    input  logic             Req2,
    input  logic [1:0]       Op1,
    input  logic [1:0]       Op2,
    input  logic [WIDTH-1:0] OpA1,
    input  logic [WIDTH-1:0] OpA2,
    input  logic [WIDTH-1:0] OpB1,
    input  logic [WIDTH-1:0] OpB2,
    output logic             Ack1,
    output logic             Ack2,
    output logic [WIDTH-1:0] Res1,
    output logic [WIDTH-1:0] Res2,
    output logic             Gnt,
    output logic             ArbBusy,
    output logic             Start,
    output logic [1:0]       MCycleOp,
    output logic [WIDTH-1:0] Operand1,
    output logic [WIDTH-1:0] Operand2,
    input  logic [WIDTH-1:0] Result1,
    input  logic [WIDTH-1:0] Result2,
    input  logic             Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic               gnt_q;
    logic               rr_q;
    logic               seen_busy_q;
    logic               start_q;
    logic               ack1_q;
    logic               ack2_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   res1_q;
    logic [WIDTH-1:0]   res2_q;

    logic               win_d;
    logic [1:0]         op_d;
    logic [WIDTH-1:0]   opa_d;
    logic [WIDTH-1:0]   opb_d;

    // rr_q names the requester preferred on a tie; it resets to requester 1,
    // independently of Gnt, so a reset always restores requester-1 priority.
    always_comb begin
        win_d = (Req1 && Req2) ? rr_q : Req2;
        op_d  = win_d ? Op2  : Op1;
        opa_d = win_d ? OpA2 : OpA1;
        opb_d = win_d ? OpB2 : OpB1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            rr_q        <= 1'b0;
            seen_busy_q <= 1'b0;
            start_q     <= 1'b0;
            ack1_q      <= 1'b0;
            ack2_q      <= 1'b0;
            op_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            res1_q      <= '0;
            res2_q      <= '0;
        end else begin
            start_q <= 1'b0;
            ack1_q  <= 1'b0;
            ack2_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Req1 || Req2) begin
                        gnt_q   <= win_d;
                        rr_q    <= ~win_d;
                        op_q    <= op_d;
                        opa_q   <= opa_d;
                        opb_q   <= opb_d;
                        start_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    seen_busy_q <= 1'b0;
                    state_q     <= RUN;
                end
                RUN: begin
                    if (Busy) begin
                        seen_busy_q <= 1'b1;
                    end
                    // Registered seen_busy means the first Busy-low cycle after a
                    // Busy-high cycle completes the operation.
                    if (seen_busy_q && !Busy) begin
                        res1_q  <= Result1;
                        res2_q  <= Result2;
                        ack1_q  <= ~gnt_q;
                        ack2_q  <= gnt_q;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Ack1     = ack1_q;
    assign Ack2     = ack2_q;
    assign Res1     = res1_q;
    assign Res2     = res2_q;
    assign Gnt      = gnt_q;
    assign ArbBusy  = (state_q != IDLE);
    assign Start    = start_q;
    assign MCycleOp = op_q;
    assign Operand1 = opa_q;
    assign Operand2 = opb_q;

endmodule

// File: tb/tb_mcycle_arbiter.sv
// Self-checking bench for mcycle_arbiter with a small behavioural MCycle (WIDTH=4).
// Table-driven single-requester vectors plus directed multi-cycle sequences.
module tb_mcycle_arbiter;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         Req1 = 1'b0, Req2 = 1'b0;
    logic [1:0]   Op1 = '0, Op2 = '0;
    logic [W-1:0] OpA1 = '0, OpA2 = '0, OpB1 = '0, OpB2 = '0;
    logic         Ack1, Ack2, Gnt, ArbBusy, Start, Busy;
    logic [W-1:0] Res1, Res2, Operand1, Operand2, Result1, Result2;
    logic [1:0]   MCycleOp;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cnt = 0;
    int last_start = 0;

    mcycle_arbiter #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET),
        .Req1(Req1), .Req2(Req2), .Op1(Op1), .Op2(Op2),
        .OpA1(OpA1), .OpA2(OpA2), .OpB1(OpB1), .OpB2(OpB2),
        .Ack1(Ack1), .Ack2(Ack2), .Res1(Res1), .Res2(Res2),
        .Gnt(Gnt), .ArbBusy(ArbBusy), .Start(Start), .MCycleOp(MCycleOp),
        .Operand1(Operand1), .Operand2(Operand2),
        .Result1(Result1), .Result2(Result2), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    // Behavioural MCycle: op[1]=divide, op[0]=unsigned; {Result2,Result1} = {high,low} or {rem,quot}.
    function automatic logic [7:0] mc_calc(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] sa, sb, sp;
        logic [7:0] ua, ub, p;
        ua = {4'b0000, a};
        ub = {4'b0000, b};
        sa = {{4{a[3]}}, a};
        sb = {{4{b[3]}}, b};
        p = '0;
        case (op)
            2'b00: begin sp = sa * sb; p = sp; end
            2'b01: p = ua * ub;
            2'b10: begin sp = sa / sb; p[3:0] = sp[3:0]; sp = sa % sb; p[7:4] = sp[3:0]; end
            default: begin p[3:0] = 4'(ua / ub); p[7:4] = 4'(ua % ub); end
        endcase
        return p;
    endfunction

    function automatic int lat_of(input logic [1:0] op);
        return op[1] ? 5 : 3;
    endfunction

    int mc_cnt;
    logic [7:0] mc_p;
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mc_cnt  <= 0;
            Result1 <= '0;
            Result2 <= '0;
        end else if (mc_cnt == 0) begin
            if (Start) begin
                mc_cnt  <= lat_of(MCycleOp);
                Result1 <= 4'b1010;
                Result2 <= 4'b0101;
            end
        end else begin
            mc_cnt <= mc_cnt - 1;
            if (mc_cnt == 1) begin
                mc_p = mc_calc(MCycleOp, Operand1, Operand2);
                Result1 <= mc_p[3:0];
                Result2 <= mc_p[7:4];
            end
        end
    end
    assign Busy = (mc_cnt != 0);

    always @(posedge CLK) begin
        if (Start) begin
            start_cnt++;
            last_start = cyc;
        end
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_ack(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (Ack1 || Ack2) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_ack_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_start(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (Start) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_start_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic chk_done(input string name, input logic g, input logic [3:0] e1, input logic [3:0] e2);
        chk({name, "_ack1"}, 32'(Ack1), 32'(!g));
        chk({name, "_ack2"}, 32'(Ack2), 32'(g));
        chk({name, "_gnt"},  32'(Gnt),  32'(g));
        chk({name, "_res1"}, 32'(Res1), 32'(e1));
        chk({name, "_res2"}, 32'(Res2), 32'(e2));
    endtask

    typedef struct {
        logic       r1;
        logic       r2;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       gnt;
        logic [3:0] e1;
        logic [3:0] e2;
        int         lat;
    } vec_t;

    vec_t vt[6];
    vec_t v;
    int   s0;
    int   st[4];

    initial begin
        vt[0] = '{1'b1, 1'b0, 2'b01, 4'b1111, 4'b1111, 1'b0, 4'b0001, 4'b1110, 5};
        vt[1] = '{1'b0, 1'b1, 2'b11, 4'b0111, 4'b1111, 1'b1, 4'b0000, 4'b0111, 7};
        vt[2] = '{1'b1, 1'b0, 2'b11, 4'b1111, 4'b0010, 1'b0, 4'b0111, 4'b0001, 7};
        vt[3] = '{1'b0, 1'b1, 2'b00, 4'b0011, 4'b1110, 1'b1, 4'b1010, 4'b1111, 5};
        vt[4] = '{1'b1, 1'b0, 2'b10, 4'b0111, 4'b1110, 1'b0, 4'b1101, 4'b0001, 7};
        vt[5] = '{1'b0, 1'b1, 2'b01, 4'b0000, 4'b1011, 1'b1, 4'b0000, 4'b0000, 5};

        // Reset state
        @(negedge CLK);
        chk("rst_start", 32'(Start), 0);
        chk("rst_ack", 32'({Ack1, Ack2}), 0);
        chk("rst_arbbusy", 32'(ArbBusy), 0);
        chk("rst_gnt", 32'(Gnt), 0);
        chk("rst_mcop", 32'(MCycleOp), 0);
        chk("rst_opnds", 32'({Operand1, Operand2}), 0);
        chk("rst_res", 32'({Res1, Res2}), 0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        // Single-requester vectors; the idle requester carries junk that must be ignored
        for (int i = 0; i < 6; i++) begin
            v = vt[i];
            @(negedge CLK);
            s0 = start_cnt;
            Req1 = v.r1;
            Req2 = v.r2;
            Op1  = v.r1 ? v.op : ~v.op;
            OpA1 = v.r1 ? v.a  : ~v.a;
            OpB1 = v.r1 ? v.b  : v.b ^ 4'b0110;
            Op2  = v.r2 ? v.op : ~v.op;
            OpA2 = v.r2 ? v.a  : ~v.a;
            OpB2 = v.r2 ? v.b  : v.b ^ 4'b0110;
            wait_ack("vec");
            chk_done("vec", v.gnt, v.e1, v.e2);
            chk("vec_latency", 32'(cyc - last_start), 32'(v.lat));
            chk("vec_starts", 32'(start_cnt - s0), 1);
            Req1 = 1'b0;
            Req2 = 1'b0;
            @(negedge CLK);
            chk("vec_idle", 32'({ArbBusy, Ack1, Ack2}), 0);
        end

        // Simultaneous requests after reset: requester 1 first
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        s0 = start_cnt;
        Req1 = 1'b1; Op1 = 2'b00; OpA1 = 4'b1111; OpB1 = 4'b1111;
        Req2 = 1'b1; Op2 = 2'b01; OpA2 = 4'b0111; OpB2 = 4'b1111;
        wait_ack("both1");
        chk_done("both1", 1'b0, 4'b0001, 4'b0000);
        Req1 = 1'b0;
        wait_ack("both2");
        chk_done("both2", 1'b1, 4'b1001, 4'b0110);
        Req2 = 1'b0;
        repeat (4) @(negedge CLK);
        chk("both_starts", 32'(start_cnt - s0), 2);

        // Continuous requests: grants alternate, Starts spaced by Busy time + 3 at least
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        s0 = start_cnt;
        Req1 = 1'b1; Op1 = 2'b01; OpA1 = 4'b1111; OpB1 = 4'b1111;
        Req2 = 1'b1; Op2 = 2'b11; OpA2 = 4'b0111; OpB2 = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_ack("rr");
            st[i] = last_start;
            if (i % 2 == 0) chk_done("rr", 1'b0, 4'b0001, 4'b1110);
            else            chk_done("rr", 1'b1, 4'b0000, 4'b0111);
            if (i > 0) chk("rr_spacing", 32'((st[i] - st[i-1]) >= ((i % 2 == 1) ? 3 : 5) + 3), 1);
        end
        Req1 = 1'b0;
        Req2 = 1'b0;
        repeat (4) @(negedge CLK);
        chk("rr_starts", 32'(start_cnt - s0), 4);
        chk("rr_idle", 32'(ArbBusy), 0);

        // Reset in the middle of RUN after a requester-1 grant
        Req1 = 1'b1; Op1 = 2'b11; OpA1 = 4'b1111; OpB1 = 4'b0010;
        wait_start("mid");
        repeat (2) @(negedge CLK);
        chk("mid_running", 32'({ArbBusy, Busy}), 32'd3);
        RESET = 1'b1;
        Req1 = 1'b0;
        #1;
        chk("mid_start", 32'(Start), 0);
        chk("mid_arbbusy", 32'(ArbBusy), 0);
        chk("mid_res", 32'({Res1, Res2}), 0);
        chk("mid_opnds", 32'({MCycleOp, Operand1, Operand2}), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("mid_no_ack", 32'({Ack1, Ack2}), 0);
        end
        RESET = 1'b0;
        @(negedge CLK);
        chk("mid_no_ack_after", 32'({Ack1, Ack2, ArbBusy}), 0);
        Req1 = 1'b1; Op1 = 2'b01; OpA1 = 4'b1111; OpB1 = 4'b1111;
        Req2 = 1'b1; Op2 = 2'b11; OpA2 = 4'b0111; OpB2 = 4'b1111;
        wait_ack("post1");
        chk_done("post1", 1'b0, 4'b0001, 4'b1110);
        Req1 = 1'b0;
        wait_ack("post2");
        chk_done("post2", 1'b1, 4'b0000, 4'b0111);
        Req2 = 1'b0;
        repeat (2) @(negedge CLK);

        // Operands change and Req drops during RUN: latched values still used, Ack still pulses
        Req1 = 1'b1; Op1 = 2'b01; OpA1 = 4'b0101; OpB1 = 4'b0011;
        wait_start("chg");
        @(negedge CLK);
        Req1 = 1'b0; Op1 = 2'b00; OpA1 = 4'b1111; OpB1 = 4'b1111;
        @(negedge CLK);
        chk("chg_operand1", 32'(Operand1), 32'h5);
        chk("chg_operand2", 32'(Operand2), 32'h3);
        chk("chg_mcop", 32'(MCycleOp), 32'h1);
        chk("chg_res_held", 32'({Res1, Res2}), 32'h07);
        wait_ack("chg");
        chk_done("chg", 1'b0, 4'b1111, 4'b0000);
        repeat (3) @(negedge CLK);
        chk("chg_idle", 32'({ArbBusy, Ack1, Ack2}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
